// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Pipeline enable/clear control, divider handshake and stall counter
//            for the 5-stage MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_stall,
    input  logic             lw_use,
    input  logic             div_req,
    input  logic             div_done,
    input  logic             dmem_stall,
    input  logic             except_flush,
    output logic             pc_en,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             clr_d,
    output logic             clr_e,
    output logic             clr_m,
    output logic             clr_w,
    output logic             div_start,
    output logic             div_abort,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        c_RUN      = 2'd0,
        c_DIV_WAIT = 2'd1,
        c_DIV_DONE = 2'd2,
        c_EXC_PEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_exc_take;
    logic             w_div_stall;

    assign w_exc_take  = (except_flush || (r_state_q == c_EXC_PEND)) && !dmem_stall;
    assign w_div_stall = ((r_state_q == c_DIV_WAIT) && !div_done) ||
                         ((r_state_q == c_RUN) && div_req);

    always_comb begin
        pc_en     = 1'b1;
        en_d      = 1'b1;
        en_e      = 1'b1;
        en_m      = 1'b1;
        en_w      = 1'b1;
        clr_d     = 1'b0;
        clr_e     = 1'b0;
        clr_m     = 1'b0;
        clr_w     = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        w_state_d = r_state_q;

        if (rst) begin
            pc_en     = 1'b0;
            en_d      = 1'b0;
            en_e      = 1'b0;
            en_m      = 1'b0;
            en_w      = 1'b0;
            w_state_d = c_RUN;
        end else if (w_exc_take) begin
            clr_d     = 1'b1;
            clr_e     = 1'b1;
            clr_m     = 1'b1;
            clr_w     = 1'b1;
            div_abort = (r_state_q == c_DIV_WAIT);
            w_state_d = c_RUN;
        end else if (dmem_stall) begin
            pc_en = 1'b0;
            en_d  = 1'b0;
            en_e  = 1'b0;
            en_m  = 1'b0;
            clr_w = 1'b1;
            // A finished division blocked here must not be restarted by div_req.
            if (except_flush || (r_state_q == c_EXC_PEND)) begin
                w_state_d = c_EXC_PEND;
            end else if ((r_state_q == c_DIV_WAIT) && div_done) begin
                w_state_d = c_DIV_DONE;
            end
        end else if (w_div_stall) begin
            pc_en = 1'b0;
            en_d  = 1'b0;
            en_e  = 1'b0;
            clr_m = 1'b1;
            if (r_state_q == c_RUN) begin
                div_start = 1'b1;
                w_state_d = c_DIV_WAIT;
            end
        end else begin
            if ((r_state_q == c_DIV_WAIT) || (r_state_q == c_DIV_DONE)) begin
                w_state_d = c_RUN;
            end
            if (lw_use) begin
                pc_en = 1'b0;
                en_d  = 1'b0;
                clr_e = 1'b1;
            end else if (imem_stall) begin
                pc_en = 1'b0;
                clr_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (!pc_en && (r_cnt_q != {CNT_W{1'b1}})) begin
            w_cnt_d = r_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_RUN;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign stall_cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Purpose  : Directed scoreboard bench for pipe_stall_ctrl (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 4;

    // Pattern bits: {pc_en, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w}
    localparam logic [8:0] c_P_RST   = 9'b00000_0000;
    localparam logic [8:0] c_P_DEF   = 9'b11111_0000;
    localparam logic [8:0] c_P_LW    = 9'b00111_0100;
    localparam logic [8:0] c_P_DIV   = 9'b00011_0010;
    localparam logic [8:0] c_P_DMEM  = 9'b00001_0001;
    localparam logic [8:0] c_P_FLUSH = 9'b11111_1111;
    localparam logic [8:0] c_P_IMEM  = 9'b01111_1000;

    typedef struct packed {
        logic [8:0]       pat;
        logic             start;
        logic             abort;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, imem_stall, lw_use, div_req, div_done, dmem_stall, except_flush;
    logic pc_en, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w;
    logic div_start, div_abort;
    logic [CNT_W-1:0] stall_cnt;

    exp_t             r_q[$];
    logic [CNT_W-1:0] r_exp_cnt;
    int               r_checks = 0;
    int               r_errors = 0;
    int               r_cyc    = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_stall   (imem_stall),
        .lw_use       (lw_use),
        .div_req      (div_req),
        .div_done     (div_done),
        .dmem_stall   (dmem_stall),
        .except_flush (except_flush),
        .pc_en        (pc_en),
        .en_d         (en_d),
        .en_e         (en_e),
        .en_m         (en_m),
        .en_w         (en_w),
        .clr_d        (clr_d),
        .clr_e        (clr_e),
        .clr_m        (clr_m),
        .clr_w        (clr_w),
        .div_start    (div_start),
        .div_abort    (div_abort),
        .stall_cnt    (stall_cnt)
    );

    // One cycle of stimulus: drive inputs, push expectation, advance the counter model.
    task automatic cyc(input logic i_rst, input logic i_imem, input logic i_lw,
                       input logic i_dreq, input logic i_ddone, input logic i_dmem,
                       input logic i_exc, input logic [8:0] i_pat,
                       input logic i_start, input logic i_abort);
        exp_t e;
        rst          = i_rst;
        imem_stall   = i_imem;
        lw_use       = i_lw;
        div_req      = i_dreq;
        div_done     = i_ddone;
        dmem_stall   = i_dmem;
        except_flush = i_exc;
        e.pat   = i_pat;
        e.start = i_start;
        e.abort = i_abort;
        e.cnt   = r_exp_cnt;
        r_q.push_back(e);
        if (i_rst) begin
            r_exp_cnt = '0;
        end else if (!i_pat[8] && (r_exp_cnt != {CNT_W{1'b1}})) begin
            r_exp_cnt = r_exp_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (r_q.size() > 0) begin
            exp_t e;
            logic [10:0] got_ctl;
            logic [10:0] exp_ctl;
            e       = r_q.pop_front();
            got_ctl = {pc_en, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w,
                       div_start, div_abort};
            exp_ctl = {e.pat, e.start, e.abort};
            r_checks = r_checks + 1;
            if (got_ctl !== exp_ctl) begin
                r_errors = r_errors + 1;
                $display("FAIL ctl cyc %0d got %b exp %b", r_cyc, got_ctl, exp_ctl);
            end
            r_checks = r_checks + 1;
            if (stall_cnt !== e.cnt) begin
                r_errors = r_errors + 1;
                $display("FAIL stall_cnt cyc %0d got %0d exp %0d", r_cyc, stall_cnt, e.cnt);
            end
            r_cyc = r_cyc + 1;
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        r_errors = r_errors + 1;
        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

    initial begin
        r_exp_cnt = '0;
        rst = 1'b1; imem_stall = 1'b1; lw_use = 1'b1; div_req = 1'b1;
        div_done = 1'b1; dmem_stall = 1'b1; except_flush = 1'b1;
        @(posedge clk);
        #1;

        //  rst imem lw dreq done dmem exc  pattern      start abort
        // Reset with every input high, then release.
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 1, 1, 1, c_P_RST, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, c_P_IMEM, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Load-use bubble.
        cyc(0, 0, 1, 0, 0, 0, 0, c_P_LW, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Division: start, five waiting cycles, done releases EX.
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, c_P_DEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Division completing under a dmem stall: no restart from DIV_DONE.
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0, c_P_DMEM, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, c_P_DMEM, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Load-use together with divider stall: divider pattern wins.
        cyc(0, 0, 1, 1, 0, 0, 0, c_P_DIV, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, c_P_DEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Exception held behind dmem stall, taken when dmem falls.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 1, c_P_DMEM, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_FLUSH, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, c_P_DMEM, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, c_P_DMEM, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, c_P_FLUSH, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Exception during DIV_WAIT aborts the divider.
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, c_P_FLUSH, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);
        // Same, with div_done arriving in the flush cycle.
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 1, c_P_FLUSH, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Reset mid-division: no abort, back in RUN afterwards.
        cyc(0, 0, 0, 1, 0, 0, 0, c_P_DIV, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, c_P_RST, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        // Twenty stalled cycles saturate the 4-bit counter at 15.
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0, 0, c_P_IMEM, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, c_P_DEF, 0, 0);

        @(negedge clk);
        #1;
        r_checks = r_checks + 1;
        if (r_q.size() != 0) begin
            r_errors = r_errors + 1;
            $display("FAIL queue_drain got %0d exp 0", r_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
